// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the sequential Booth multiplier.
//   booth_state_t - controller states
//   cnt_width()   - width of the iteration counter for a given operand width
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        RUN,
        OUT_HI,
        OUT_LO
    } booth_state_t;

    // The counter is loaded with w+1, so it must be able to hold that value.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if: operand load bus and back-pressured result bus.
//   enable, signed_mode, inbus : controller -> multiplier (one operand beat per enable)
//   ready                      : multiplier idle, next beat is the multiplicand
//   done                       : one-cycle pulse when the product becomes available
//   out_valid, outbus          : product beats, high half first
//   out_ready                  : consumer accepts the current product beat
// Modports: master = controller/consumer side, slave = multiplier side.
interface booth_mul_seq_if #(
    parameter int unsigned W = 8
);
    logic         enable;
    logic         signed_mode;
    logic [W-1:0] inbus;
    logic         ready;
    logic         done;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] outbus;

    modport master (
        output enable,
        output signed_mode,
        output inbus,
        output out_ready,
        input  ready,
        input  done,
        input  out_valid,
        input  outbus
    );

    modport slave (
        input  enable,
        input  signed_mode,
        input  inbus,
        input  out_ready,
        output ready,
        output done,
        output out_valid,
        output outbus
    );
endinterface

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration.
//   a, q, qm1  : current accumulator (W+2), multiplier (W+1) and the bit shifted out last
//   m          : multiplicand extended to W+2 bits
//   a_nxt, q_nxt, qm1_nxt : state after the add/sub and arithmetic right shift of {A,Q,q-1}
module booth_step #(
    parameter int unsigned W = 8
) (
    input  logic [W+1:0] a,
    input  logic [W:0]   q,
    input  logic         qm1,
    input  logic [W+1:0] m,
    output logic [W+1:0] a_nxt,
    output logic [W:0]   q_nxt,
    output logic         qm1_nxt
);
    logic [W+1:0] sum;

    always_comb begin
        sum = a;
        unique case ({q[0], qm1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
    end

    // Arithmetic shift: sign of the new accumulator is replicated into the top.
    assign a_nxt   = {sum[W+1], sum[W+1:1]};
    assign q_nxt   = {sum[0], q[W:1]};
    assign qm1_nxt = q[0];
endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier, signed or unsigned per operation.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : booth_mul_seq_if slave port
//              load M then Q over inbus with enable; W+1 iterations; product read out as
//              two W-bit beats (high half first) under out_valid/out_ready.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst,
    booth_mul_seq_if.slave    bus
);
    localparam int unsigned CntW = cnt_width(W);

    booth_state_t state_q, state_d;

    logic [W-1:0]  m_q;
    logic          mode_q;
    logic [W:0]    q_q;
    logic [W+1:0]  a_q;
    logic          qm1_q;
    logic [CntW-1:0] cnt_q;
    logic          done_q;

    logic [W+1:0]  m_ext;
    logic [W:0]    q_ext;
    logic [W+1:0]  a_nxt;
    logic [W:0]    q_nxt;
    logic          qm1_nxt;
    logic [2*W-1:0] prod;
    logic          last_iter;

    // Operands are widened by one bit so unsigned values stay positive in the signed
    // Booth recoding; this also makes the most-negative signed operand safe.
    assign m_ext = {{2{mode_q & m_q[W-1]}}, m_q};
    assign q_ext = {mode_q & bus.inbus[W-1], bus.inbus};

    // Low 2W bits of {A,Q}: Q supplies W+1 bits, A the remaining W-1.
    assign prod = {a_q[W-2:0], q_q};

    assign last_iter = (state_q == RUN) && (cnt_q == CntW'(1));

    booth_step #(
        .W (W)
    ) u_step (
        .a       (a_q),
        .q       (q_q),
        .qm1     (qm1_q),
        .m       (m_ext),
        .a_nxt   (a_nxt),
        .q_nxt   (q_nxt),
        .qm1_nxt (qm1_nxt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.enable) state_d = LOAD_Q;
            LOAD_Q:  if (bus.enable) state_d = RUN;
            RUN:     if (last_iter) state_d = OUT_HI;
            OUT_HI:  if (bus.out_ready) state_d = OUT_LO;
            OUT_LO:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: decoded from registered state and registered datapath only.
    always_comb begin
        bus.ready     = 1'b0;
        bus.out_valid = 1'b0;
        bus.outbus    = '0;
        bus.done      = done_q;
        unique case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
            end
            OUT_HI: begin
                bus.out_valid = 1'b1;
                bus.outbus    = prod[2*W-1:W];
            end
            OUT_LO: begin
                bus.out_valid = 1'b1;
                bus.outbus    = prod[W-1:0];
            end
            default: begin
                bus.ready = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= '0;
            mode_q <= 1'b0;
            q_q    <= '0;
            a_q    <= '0;
            qm1_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            // Pulse coincides with the first OUT_HI cycle.
            done_q <= last_iter;
            unique case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        m_q    <= bus.inbus;
                        mode_q <= bus.signed_mode;
                    end
                end
                LOAD_Q: begin
                    if (bus.enable) begin
                        q_q   <= q_ext;
                        a_q   <= '0;
                        qm1_q <= 1'b0;
                        cnt_q <= CntW'(W + 1);
                    end
                end
                RUN: begin
                    a_q   <= a_nxt;
                    q_q   <= q_nxt;
                    qm1_q <= qm1_nxt;
                    cnt_q <= cnt_q - CntW'(1);
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed self-checking bench for booth_mul_seq at W=8 and W=16.
module tb_booth_mul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    booth_mul_seq_if #(.W(8))  b8 ();
    booth_mul_seq_if #(.W(16)) b16 ();

    booth_mul_seq #(.W(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    booth_mul_seq #(.W(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // M beat, Q beat (signed_mode flipped on the Q beat to show it is ignored), then
    // verify out_valid rises exactly 9 edges after the Q edge together with done.
    task automatic start8(input logic [7:0] m, input logic [7:0] q, input logic sm,
                          input string tag);
        check({tag, ".ready_before"}, 32'(b8.ready), 32'd1);
        b8.enable      = 1'b1;
        b8.signed_mode = sm;
        b8.inbus       = m;
        tick();
        check({tag, ".ready_after_m"}, 32'(b8.ready), 32'd0);
        b8.signed_mode = ~sm;
        b8.inbus       = q;
        tick();
        b8.enable = 1'b0;
        b8.inbus  = 8'h00;
        repeat (8) tick();
        check({tag, ".valid_early"}, 32'(b8.out_valid), 32'd0);
        tick();
        check({tag, ".valid"}, 32'(b8.out_valid), 32'd1);
        check({tag, ".done"}, 32'(b8.done), 32'd1);
    endtask

    task automatic drain8(input logic [7:0] hi, input logic [7:0] lo, input string tag);
        check({tag, ".hi"}, 32'(b8.outbus), 32'(hi));
        b8.out_ready = 1'b1;
        tick();
        check({tag, ".done_once"}, 32'(b8.done), 32'd0);
        check({tag, ".lo"}, 32'(b8.outbus), 32'(lo));
        check({tag, ".lo_valid"}, 32'(b8.out_valid), 32'd1);
        tick();
        b8.out_ready = 1'b0;
        check({tag, ".ready_end"}, 32'(b8.ready), 32'd1);
        check({tag, ".valid_end"}, 32'(b8.out_valid), 32'd0);
        check({tag, ".bus_end"}, 32'(b8.outbus), 32'd0);
    endtask

    task automatic run16(input logic [15:0] m, input logic [15:0] q, input int gap,
                         input logic [15:0] hi, input logic [15:0] lo, input string tag);
        check({tag, ".ready_before"}, 32'(b16.ready), 32'd1);
        b16.enable      = 1'b1;
        b16.signed_mode = 1'b1;
        b16.inbus       = m;
        tick();
        b16.signed_mode = 1'b0;
        b16.enable      = 1'b0;
        repeat (gap) tick();
        check({tag, ".wait_q"}, 32'(b16.ready), 32'd0);
        b16.enable = 1'b1;
        b16.inbus  = q;
        tick();
        b16.enable = 1'b0;
        repeat (16) tick();
        check({tag, ".valid_early"}, 32'(b16.out_valid), 32'd0);
        tick();
        check({tag, ".valid"}, 32'(b16.out_valid), 32'd1);
        check({tag, ".done"}, 32'(b16.done), 32'd1);
        check({tag, ".hi"}, 32'(b16.outbus), 32'(hi));
        b16.out_ready = 1'b1;
        tick();
        check({tag, ".lo"}, 32'(b16.outbus), 32'(lo));
        tick();
        b16.out_ready = 1'b0;
        check({tag, ".ready_end"}, 32'(b16.ready), 32'd1);
    endtask

    initial begin
        b8.enable       = 1'b0;
        b8.signed_mode  = 1'b0;
        b8.inbus        = '0;
        b8.out_ready    = 1'b0;
        b16.enable      = 1'b0;
        b16.signed_mode = 1'b0;
        b16.inbus       = '0;
        b16.out_ready   = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst.ready", 32'(b8.ready), 32'd1);
        check("rst.done", 32'(b8.done), 32'd0);
        check("rst.valid", 32'(b8.out_valid), 32'd0);
        check("rst.outbus", 32'(b8.outbus), 32'd0);
        rst = 1'b0;
        tick();

        // -3 * 5 = -15
        start8(8'hFD, 8'h05, 1'b1, "s_m3x5");
        drain8(8'hFF, 8'hF1, "s_m3x5");

        // 255 * 255 unsigned, then -1 * -1 signed
        start8(8'hFF, 8'hFF, 1'b0, "u_ffxff");
        drain8(8'hFE, 8'h01, "u_ffxff");
        start8(8'hFF, 8'hFF, 1'b1, "s_ffxff");
        drain8(8'h00, 8'h01, "s_ffxff");

        // Signed corners.
        start8(8'h80, 8'h80, 1'b1, "s_80x80");
        drain8(8'h40, 8'h00, "s_80x80");
        start8(8'h80, 8'h7F, 1'b1, "s_80x7f");
        drain8(8'hC0, 8'h80, "s_80x7f");
        start8(8'h00, 8'h5A, 1'b1, "s_00x5a");
        drain8(8'h00, 8'h00, "s_00x5a");

        // Back-pressure in OUT_HI while enable is pulsed with junk operands.
        start8(8'hFD, 8'h05, 1'b1, "bp");
        for (int i = 0; i < 5; i++) begin
            b8.enable = i[0];
            b8.inbus  = 8'h3C;
            tick();
            check("bp.hold_bus", 32'(b8.outbus), 32'hFF);
            check("bp.hold_ready", 32'(b8.ready), 32'd0);
            check("bp.hold_valid", 32'(b8.out_valid), 32'd1);
        end
        b8.enable    = 1'b0;
        b8.out_ready = 1'b1;
        tick();
        check("bp.lo", 32'(b8.outbus), 32'hF1);
        tick();
        b8.out_ready = 1'b0;
        check("bp.ready", 32'(b8.ready), 32'd1);

        // Reset in the middle of RUN.
        b8.enable      = 1'b1;
        b8.signed_mode = 1'b0;
        b8.inbus       = 8'h12;
        tick();
        b8.inbus = 8'h34;
        tick();
        b8.enable = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("mid_rst.valid", 32'(b8.out_valid), 32'd0);
        check("mid_rst.outbus", 32'(b8.outbus), 32'd0);
        check("mid_rst.ready", 32'(b8.ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        start8(8'h07, 8'h06, 1'b0, "after_rst");
        drain8(8'h00, 8'h2A, "after_rst");

        // W=16 signed: -1234 * 567, then the same with a 3-cycle gap before Q.
        run16(16'hFB2E, 16'h0237, 0, 16'hFFF5, 16'h52E2, "w16");
        run16(16'hFB2E, 16'h0237, 3, 16'hFFF5, 16'h52E2, "w16_gap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Parametrised sequential radix-2 Booth multiplier with a W-bit byte-serial load bus and a handshaked two-beat result bus. It is the successor to the fixed 8-bit Booth datapath:

- Width is a parameter.
- Signed or unsigned operation is selected per operation.
- Result read-out is back-pressured.

It sits on a narrow shared data bus between a controller that streams operands and a consumer that drains the 2W-bit product.

## Interface
- W, 8, operand width in bits (W ≥ 4); product is 2W bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  load strobe; one beat captured from inbus per cycle enable=1 while loading
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the M beat
- inbus  in  W  operand bus: first beat M (multiplicand), second beat Q (multiplier)
- ready  out  1  high in IDLE only: next enable beat is taken as M
- done  out  1  one-cycle pulse on the cycle RUN→OUT_HI occurs
- out_valid  out  1  high while outbus carries a product beat
- out_ready  in  1  consumer accepts current beat when out_valid & out_ready
- outbus  out  W  product beat: high half P[2W-1:W] first, then low half P[W-1:0]; 0 when out_valid=0

## Operation
- States: IDLE, LOAD_Q, RUN, OUT_HI, OUT_LO.
- IDLE:
  - enable=1 → M←inbus, mode←signed_mode → LOAD_Q.
  - enable=0 → stay.
- LOAD_Q:
  - enable=1 → Q←inbus, A←0, q₋₁←0, cnt←W+1 → RUN.
  - enable=0 → wait indefinitely.
- Extension: M and Q are extended to W+1 bits (sign-extended if mode=1, zero-extended if mode=0); A is W+2 bits, M sign-extended to W+2 for add/sub.
- RUN, one iteration per cycle on {Q[0], q₋₁}:
  - 01 → A←A+M
  - 10 → A←A−M
  - 00/11 → no add
  - Then arithmetic right shift of {A,Q,q₋₁} by one; cnt←cnt−1.
  - After the iteration where cnt was 1 → OUT_HI, with done pulse.
- Exactly W+1 iterations in both modes. P = low 2W bits of {A,Q}; this is correct for every signed and unsigned input, including M or Q = most-negative.
- OUT_HI: out_valid=1, outbus=P[2W-1:W]; on out_ready → OUT_LO.
- OUT_LO: out_valid=1, outbus=P[W-1:0]; on out_ready → IDLE.
- enable is ignored in RUN, OUT_HI and OUT_LO (no queuing, no abort). signed_mode is ignored outside the M beat.
- rst asserted in any state:
  - All registers clear, state IDLE.
  - Any in-flight product is discarded; no partial beat is emitted.

## Timing
- Reset values: ready=1, done=0, out_valid=0, outbus=0; internal M, Q, A, cnt, mode all 0.
- The M beat is taken at the first edge with ready & enable. The earliest Q beat is the next edge.
- From the Q-capture edge, out_valid rises after W+1 edges. For W=8 that is 9 cycles; with out_ready held high, the op is done 11 cycles after the Q beat.
- done and out_valid rise in the same cycle.
- Each output beat is held stable until accepted. outbus changes only on an accepted beat.
- ready rises the cycle after the OUT_LO beat is accepted. Minimum op-to-op spacing: 2 + (W+1) + 2 cycles.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Structure
- Package booth_pkg:
  - booth_state_t enum {IDLE, LOAD_Q, RUN, OUT_HI, OUT_LO}
  - function for the iteration-counter width, $clog2(W+2)
- Sub-module booth_step: purely combinational single Booth iteration.
  - Inputs: A, Q, q₋₁, M (extended widths).
  - Outputs: next A, Q, q₋₁ after add/sub and arithmetic shift.
- The top instantiates booth_step once, plus the FSM, operand registers and output mux.

## Test plan
- W=8, signed: M=0xFD (−3), Q=0x05 → out_valid 9 cycles after the Q edge; beats 0xFF then 0xF1 (−15); done pulses once.
- W=8, unsigned: M=0xFF, Q=0xFF → beats 0xFE, 0x01 (65025). Repeat with signed_mode=1 → beats 0x00, 0x01 (+1).
- W=8, signed corners:
  - M=0x80, Q=0x80 → 0x40, 0x00 (16384)
  - M=0x80, Q=0x7F → 0xC0, 0x80 (−16256)
  - M=0x00, Q=0x5A → 0x00, 0x00
- Back-pressure:
  - Hold out_ready=0 for 5 cycles in OUT_HI while pulsing enable → outbus stays 0xFF, ready stays 0, no operand change.
  - Then out_ready=1 → 0xF1, then ready=1.
- Reset mid-RUN: assert rst at iteration 4 → out_valid=0, outbus=0, ready=1 immediately. The next op M=7, Q=6 → beats 0x00, 0x2A.
- W=16, signed: M=−1234, Q=567 → beats 0xFFF5, 0x52E2 (−699678), 17 cycles after the Q edge. Q beat delayed 3 cycles after M → same result.
